// File: rtl/sort_run_controller.sv
// rtl/sort_run_controller.sv - streams an array into data memory, runs the core, detects halt.
// Optional feature: define RUN_CTRL_TIMEOUT_EN to enable the MAX_CYCLES run limit and the ERR state.
module sort_run_controller #(
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          LEN_W        = 8,
  parameter int          CNT_W        = 32,
  parameter int          HALT_CONFIRM = 2,
  parameter int          MAX_CYCLES   = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] num_elems,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [63:0]      ld_data,
  output logic             mem_sel,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  output logic             core_reset,
  input  logic [63:0]      core_pc,
  input  logic [63:0]      core_next_pc,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] HALT_LIM = 4'(HALT_CONFIRM);

  if (HALT_CONFIRM < 1 || HALT_CONFIRM > 15 || MAX_CYCLES < 1) begin : g_bad_param
    $error("sort_run_controller: HALT_CONFIRM must be 1..15 and MAX_CYCLES >= 1");
  end

  state_t           state, state_n;
  logic [LEN_W-1:0] index, index_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [3:0]       halt_cnt, halt_n;
  logic             mem_sel_n, mem_we_n, core_reset_n, busy_n, done_n;
  logic [63:0]      mem_addr_n, mem_wdata_n;
  logic [CNT_W-1:0] cnt_n;
  logic             hs, self_loop, halt_hit;

  assign ld_ready  = (state == S_LOAD);
  assign hs        = ld_valid & ld_ready;
  assign self_loop = (core_pc == core_next_pc);
  assign halt_hit  = self_loop && ((halt_cnt + 4'd1) == HALT_LIM);

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_CYCLES);
  logic error_q, error_n;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    index_n      = index;
    len_n        = len_q;
    halt_n       = halt_cnt;
    mem_sel_n    = mem_sel;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    core_reset_n = core_reset;
    done_n       = done;
    cnt_n        = cycle_count;
`ifdef RUN_CTRL_TIMEOUT_EN
    error_n      = error_q;
`endif
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          len_n        = num_elems;
          index_n      = '0;
          halt_n       = '0;
          cnt_n        = '0;
          done_n       = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
          error_n      = 1'b0;
`endif
          mem_sel_n    = 1'b1;
          core_reset_n = 1'b1;
          state_n      = (num_elems != '0) ? S_LOAD : S_FLUSH;
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = BASE_ADDR + (64'(index) << 3);
          mem_wdata_n = ld_data;
          index_n     = index + 1'b1;
          if (index == len_q - LEN_W'(1)) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The last array word is being written this cycle; hand memory to the core next.
        mem_sel_n    = 1'b0;
        core_reset_n = 1'b0;
        state_n      = S_RUN;
      end
      S_RUN: begin
        cnt_n  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
        halt_n = self_loop ? halt_cnt + 4'd1 : 4'd0;
        if (halt_hit) begin
          done_n       = 1'b1;
          core_reset_n = 1'b1;
          state_n      = S_DONE;
        end
`ifdef RUN_CTRL_TIMEOUT_EN
        else if (cnt_n == MAX_LIM) begin
          error_n      = 1'b1;
          core_reset_n = 1'b1;
          state_n      = S_ERR;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_LOAD) || (state_n == S_FLUSH) || (state_n == S_RUN);
  end

  // Data memory itself is outside this block and never sees core_reset, so results persist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      index       <= '0;
      len_q       <= '0;
      halt_cnt    <= '0;
      mem_sel     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
`ifdef RUN_CTRL_TIMEOUT_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      index       <= index_n;
      len_q       <= len_n;
      halt_cnt    <= halt_n;
      mem_sel     <= mem_sel_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      core_reset  <= core_reset_n;
      busy        <= busy_n;
      done        <= done_n;
      cycle_count <= cnt_n;
`ifdef RUN_CTRL_TIMEOUT_EN
      error_q     <= error_n;
`endif
    end
  end

endmodule

// File: doc/sort_run_controller.md
Name: sort_run_controller

Overview:
- Sequences one complete run of the single-cycle RISC-V core: streams an input array into data memory, releases the core from reset, detects program halt, and reports cycle count and completion.
- Sits between the testbench/host and the processor top.
- Owns the core's reset line and a write port into data memory.
- Owns the select line of the data-memory port mux: controller port vs core port.

Parameters:
- BASE_ADDR, 64'h0: byte address of array element 0. Element i is written at BASE_ADDR + 8*i.
- LEN_W, 8: width of the element-count input.
- CNT_W, 32: width of the cycle counter.
- HALT_CONFIRM, 2: consecutive self-loop cycles required to declare halt. Legal range 1..15.
- MAX_CYCLES, 100000: run-cycle limit. Used only with the optional timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; begins a run. Honoured only in IDLE, DONE or ERR.
- num_elems  in  LEN_W  element count, captured when start is accepted.
- ld_valid  in  1  load data valid.
- ld_ready  out  1  controller accepts a load word.
- ld_data  in  64  load word.
- mem_sel  out  1  1 = data memory driven by the controller port.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  64  data-memory byte address.
- mem_wdata  out  64  data-memory write data.
- core_reset  out  1  reset to the processor core.
- core_pc  in  64  PC_Out of the core.
- core_next_pc  in  64  PC_In of the core.
- busy  out  1  state is LOAD, FLUSH or RUN.
- done  out  1  halt detected.
- error  out  1  timeout occurred.
- cycle_count  out  CNT_W  core cycles executed in the current or last run.

Behaviour:
- All outputs are registered except ld_ready, which equals (state==LOAD).
- Reset values: state IDLE, core_reset=1, mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cycle_count=0, index=0, halt counter=0.
- Reset mid-operation forces these values immediately; no pending write completes.
- Data memory must not be tied to core_reset, so array contents survive DONE.
- States: IDLE, LOAD, FLUSH, RUN, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Capture num_elems; clear done, error, cycle_count, index.
  - Go to LOAD if num_elems != 0, else go to FLUSH.
- LOAD (mem_sel=1, core_reset=1):
  - A handshake is ld_valid & ld_ready at cycle t.
  - In cycle t+1: mem_we=1, mem_addr=BASE_ADDR + (index<<3), mem_wdata=ld_data; index increments.
  - With no handshake, mem_we=0 next cycle.
  - The handshake with index == num_elems-1 moves the state to FLUSH.
- FLUSH: exactly one cycle, mem_sel=1; the final write is committed. Next state RUN.
- RUN:
  - mem_sel=0, core_reset=0; both change on the edge entering RUN.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Halt counter increments while core_pc == core_next_pc (branch-to-self) and clears otherwise.
  - When the halt counter reaches HALT_CONFIRM, go to DONE.
- DONE: done=1, core_reset=1, cycle_count frozen.
- ld_valid is ignored outside LOAD.
- start is ignored while busy.
- A start in DONE/ERR on the same cycle it is entered is honoured next cycle.

Optional Feature:
- Macro RUN_CTRL_TIMEOUT_EN.
- Defined: in RUN, if cycle_count reaches MAX_CYCLES without halt, go to ERR. ERR sets error=1, core_reset=1, cycle_count frozen at MAX_CYCLES. If halt and the limit occur in the same cycle, halt wins (DONE).
- Undefined: ERR is unreachable, error is tied to 0, and RUN continues indefinitely.

Test Plan:
- Reset, then start with num_elems=4 and words 5,3,9,1 with ld_valid held high → mem_we pulses at addresses 0x0, 0x8, 0x10, 0x18 with those data; FLUSH; core_reset falls 6 cycles after start.
- Load 3 words with ld_valid gaps of 2 cycles → exactly 3 writes, no extra mem_we, correct sequential addresses.
- Program reaches self-loop at PC 0x40 after 20 cycles, HALT_CONFIRM=2 → done=1 and core_reset=1; cycle_count = 21 (first self-loop cycle is cycle 20 of RUN, so the halt counter reaches 2 on cycle 21); later reads of 0x0..0x18 return the sorted array.
- num_elems=0 → no mem_we; IDLE→FLUSH→RUN.
- Assert reset during LOAD after 2 writes → mem_we=0 and core_reset=1 immediately; state IDLE; a new start reloads from BASE_ADDR.
- With RUN_CTRL_TIMEOUT_EN and MAX_CYCLES=50, core never halts → error=1 and cycle_count=50. Without the macro → error stays 0 past 100 cycles.
